time_syn_ctrl: RTL and testbench
================================

// Module: time_syn_ctrl
// PURPOSE
//  Master-side sequencer for the time-sync exchange on the ctrl AXIS link.
//  - On a slot-start pulse, sends a TS frame carrying the local time, then waits for the peer's RETURN frame.
//  - Computes round-trip and one-way link delay from the echoed timestamp.
//  - Sends an STD frame carrying local time + one-way delay.
//  - Sits between the local time counter, the sync RX decoder and the ctrl TX AXIS port.
// PARAMETERS
//  P_TS_PRE       64'h66     preamble beat of a TS frame
//  P_STD_PRE      64'h88     preamble beat of an STD frame
//  P_TIMEOUT_CYC  32'd4096   cycles to wait for RETURN before retry (TIME_SYN_TIMEOUT_EN only)
//  P_MAX_RETRY    4'd3       TS resends before declaring failure (TIME_SYN_TIMEOUT_EN only)
// PORTS
//  i_clk                  in   1   clock
//  i_rst_n                in   1   asynchronous reset, active-low
//  i_local_time           in   64  free-running local time counter
//  i_syn_start            in   1   one-cycle pulse: start a sync exchange
//  i_recv_return_ts       in   64  echoed timestamp from the RETURN frame
//  i_recv_return_valid    in   1   one-cycle pulse qualifying i_recv_return_ts
//  m_ctrl_tx_axis_tvalid  out  1   AXIS valid
//  m_ctrl_tx_axis_tdata   out  64  AXIS data
//  m_ctrl_tx_axis_tlast   out  1   AXIS last (beat 1 of each frame)
//  m_ctrl_tx_axis_tkeep   out  8   AXIS keep, always 8'hFF while valid
//  m_ctrl_tx_axis_tuser   out  1   AXIS user, always 0
//  m_ctrl_tx_axis_tready  in   1   AXIS ready
//  o_link_delay           out  64  last one-way delay = rtt >> 1
//  o_delay_valid          out  1   one-cycle pulse when o_link_delay updates
//  o_syn_busy             out  1   high whenever FSM != IDLE
//  o_syn_fail             out  1   one-cycle pulse when retries are exhausted
// BEHAVIOUR
//  - Reset: all outputs 0, FSM=IDLE, retry count 0, internal timestamps 0.
//  - FSM: IDLE -> TS0 -> TS1 -> WAIT_RET -> CALC -> STD0 -> STD1 -> IDLE.
//  - IDLE:
//    - i_syn_start=1: capture r_sent_ts <= i_local_time; go to TS0. tvalid rises the next cycle.
//    - i_syn_start in any other state is ignored.
//  - TS0: tdata=P_TS_PRE, tlast=0. Advance to TS1 on tvalid&tready.
//  - TS1: tdata=r_sent_ts, tlast=1. On handshake, go to WAIT_RET and clear the wait counter.
//  - Frame data is held stable while tvalid=1 and tready=0. tvalid never drops mid-frame.
//  - WAIT_RET: accept i_recv_return_valid only if i_recv_return_ts == r_sent_ts.
//    - Accepted: rtt <= i_local_time - r_sent_ts (64-bit modulo, wrap-safe); go to CALC.
//    - Mismatched echo is dropped; FSM stays in WAIT_RET.
//  - CALC (1 cycle):
//    - o_link_delay <= rtt >> 1; o_delay_valid=1 for that cycle.
//    - r_std_time <= i_local_time + (rtt >> 1), modulo 2^64.
//    - Go to STD0.
//  - STD0: tdata=P_STD_PRE. STD1: tdata=r_std_time, tlast=1. STD1 handshake -> IDLE.
//  - A return pulse coinciding with i_syn_start in IDLE is ignored. The new exchange starts normally.
//  - Asynchronous reset mid-frame drops tvalid immediately. No partial frame is completed.
// CONFIGURATION
//  TIME_SYN_TIMEOUT_EN defined:
//  - Wait counter increments every WAIT_RET cycle.
//  - On reaching P_TIMEOUT_CYC-1 with no accepted return:
//    - retry count < P_MAX_RETRY: retry++, recapture r_sent_ts, go to TS0.
//    - else: o_syn_fail pulses 1 cycle, retry cleared, go to IDLE.
//  - Retry count clears on entry from IDLE.
//  TIME_SYN_TIMEOUT_EN undefined:
//  - WAIT_RET waits indefinitely.
//  - o_syn_fail is tied 0.
//  - Timeout and retry logic are not synthesised.
// TESTING
//  - Start with local_time=1000, tready=1:
//    -> beats 0x66, then 1000 (tlast=1) on the cycles after start.
//    -> RETURN echo 1000 at local_time=1100 gives o_link_delay=50 with o_delay_valid.
//    -> STD beats 0x88, then local_time_at_CALC+50.
//  - tready=0 for 5 cycles during TS1 -> tdata/tlast held; exactly 2 TS beats transferred.
//  - RETURN with echo 999 while waiting on 1000 -> ignored; a later echo 1000 completes the exchange.
//  - r_sent_ts=64'hFFFF_FFFF_FFFF_FFF0, return at local_time=64'h10 -> rtt=0x20, o_link_delay=0x10.
//  - With TIME_SYN_TIMEOUT_EN, P_TIMEOUT_CYC=16, no RETURN:
//    -> 4 TS frames total (1 initial + 3 retries).
//    -> then o_syn_fail pulse, busy=0.
//  - Assert i_rst_n=0 during STD0 -> tvalid=0 and busy=0 at once; after release, a new start runs cleanly.

Source files
------------

// File: rtl/time_syn_ctrl.sv
// -----------------------------------------------------------------------------
// time_syn_ctrl
//   Master-side sequencer for the time-sync exchange on the ctrl AXIS link.
//   On a slot-start pulse it sends a TS frame (preamble + local time), waits
//   for the peer's RETURN echo of that timestamp, derives round-trip and
//   one-way delay, then sends an STD frame carrying local time + one-way delay.
//
// Optional feature macro: TIME_SYN_TIMEOUT_EN
//   Defined   : WAIT_RET times out after P_TIMEOUT_CYC cycles and resends the
//               TS frame up to P_MAX_RETRY times, then pulses o_syn_fail.
//   Undefined : WAIT_RET waits indefinitely and o_syn_fail is tied low.
//
// Ports
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_local_time            free-running local time counter
//   i_syn_start             one-cycle pulse that starts an exchange (IDLE only)
//   i_recv_return_ts/valid  echoed timestamp from the RETURN frame
//   m_ctrl_tx_axis_*        AXIS master for TS/STD frames (2 beats each)
//   o_link_delay            last one-way delay (rtt >> 1)
//   o_delay_valid           one-cycle pulse when o_link_delay updates
//   o_syn_busy              high whenever the sequencer is not idle
//   o_syn_fail              one-cycle pulse when retries are exhausted
// -----------------------------------------------------------------------------
module time_syn_ctrl #(
    parameter logic [63:0] P_TS_PRE      = 64'h66,
    parameter logic [63:0] P_STD_PRE     = 64'h88,
    parameter logic [31:0] P_TIMEOUT_CYC = 32'd4096,
    parameter logic [3:0]  P_MAX_RETRY   = 4'd3
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [63:0] i_local_time,
    input  logic        i_syn_start,
    input  logic [63:0] i_recv_return_ts,
    input  logic        i_recv_return_valid,
    output logic        m_ctrl_tx_axis_tvalid,
    output logic [63:0] m_ctrl_tx_axis_tdata,
    output logic        m_ctrl_tx_axis_tlast,
    output logic [7:0]  m_ctrl_tx_axis_tkeep,
    output logic        m_ctrl_tx_axis_tuser,
    input  logic        m_ctrl_tx_axis_tready,
    output logic [63:0] o_link_delay,
    output logic        o_delay_valid,
    output logic        o_syn_busy,
    output logic        o_syn_fail
);

    typedef enum logic [2:0] {
        IDLE, TS0, TS1, WAIT_RET, CALC, STD0, STD1
    } state_t;

    state_t      state, state_next;
    logic [63:0] r_sent_ts;
    logic [63:0] r_rtt;
    logic [63:0] r_std_time;
    logic        ret_ok;

    // One-way delay is half the round trip, truncated toward zero.
    function automatic logic [63:0] half_delay(input logic [63:0] rtt);
        return rtt >> 1;
    endfunction

    // Only an echo of the timestamp we actually sent closes the exchange.
    assign ret_ok = (state == WAIT_RET) && i_recv_return_valid &&
                    (i_recv_return_ts == r_sent_ts);

`ifdef TIME_SYN_TIMEOUT_EN
    logic [31:0] wait_cnt;
    logic [3:0]  retry_cnt;
    logic        timeout;
    logic        do_retry;
    logic        do_fail;

    assign timeout  = (state == WAIT_RET) && !ret_ok &&
                      (wait_cnt == P_TIMEOUT_CYC - 32'd1);
    assign do_retry = timeout && (retry_cnt < P_MAX_RETRY);
    assign do_fail  = timeout && !do_retry;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wait_cnt   <= '0;
            retry_cnt  <= '0;
            o_syn_fail <= 1'b0;
        end else begin
            if (state == TS1 && m_ctrl_tx_axis_tready)
                wait_cnt <= '0;
            else if (state == WAIT_RET)
                wait_cnt <= wait_cnt + 32'd1;

            if (state == IDLE && i_syn_start)
                retry_cnt <= '0;
            else if (do_retry)
                retry_cnt <= retry_cnt + 4'd1;
            else if (do_fail)
                retry_cnt <= '0;

            o_syn_fail <= do_fail;
        end
    end
`else
    assign o_syn_fail = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Frame beats are decoded straight from the state register so that an
    // asynchronous reset drops tvalid immediately and a stalled beat holds.
    always_comb begin
        state_next            = state;
        m_ctrl_tx_axis_tvalid = 1'b0;
        m_ctrl_tx_axis_tdata  = '0;
        m_ctrl_tx_axis_tlast  = 1'b0;
        case (state)
            IDLE: begin
                if (i_syn_start)
                    state_next = TS0;
            end
            TS0: begin
                m_ctrl_tx_axis_tvalid = 1'b1;
                m_ctrl_tx_axis_tdata  = P_TS_PRE;
                if (m_ctrl_tx_axis_tready)
                    state_next = TS1;
            end
            TS1: begin
                m_ctrl_tx_axis_tvalid = 1'b1;
                m_ctrl_tx_axis_tdata  = r_sent_ts;
                m_ctrl_tx_axis_tlast  = 1'b1;
                if (m_ctrl_tx_axis_tready)
                    state_next = WAIT_RET;
            end
            WAIT_RET: begin
                if (ret_ok)
                    state_next = CALC;
`ifdef TIME_SYN_TIMEOUT_EN
                else if (do_retry)
                    state_next = TS0;
                else if (do_fail)
                    state_next = IDLE;
`endif
            end
            CALC: begin
                state_next = STD0;
            end
            STD0: begin
                m_ctrl_tx_axis_tvalid = 1'b1;
                m_ctrl_tx_axis_tdata  = P_STD_PRE;
                if (m_ctrl_tx_axis_tready)
                    state_next = STD1;
            end
            STD1: begin
                m_ctrl_tx_axis_tvalid = 1'b1;
                m_ctrl_tx_axis_tdata  = r_std_time;
                m_ctrl_tx_axis_tlast  = 1'b1;
                if (m_ctrl_tx_axis_tready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign m_ctrl_tx_axis_tkeep = {8{m_ctrl_tx_axis_tvalid}};
    assign m_ctrl_tx_axis_tuser = 1'b0;
    assign o_syn_busy           = (state != IDLE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sent_ts     <= '0;
            r_rtt         <= '0;
            r_std_time    <= '0;
            o_link_delay  <= '0;
            o_delay_valid <= 1'b0;
        end else begin
            if (state == IDLE && i_syn_start)
                r_sent_ts <= i_local_time;
`ifdef TIME_SYN_TIMEOUT_EN
            // Each resend carries a fresh timestamp.
            if (do_retry)
                r_sent_ts <= i_local_time;
`endif
            // Modulo-2^64 subtraction keeps the round trip correct across a
            // wrap of the local time counter.
            if (ret_ok)
                r_rtt <= i_local_time - r_sent_ts;

            // Delay and its valid pulse are registered together so the pulse
            // coincides with the new o_link_delay value.
            o_delay_valid <= (state == CALC);
            if (state == CALC) begin
                o_link_delay <= half_delay(r_rtt);
                r_std_time   <= i_local_time + half_delay(r_rtt);
            end
        end
    end

endmodule

// File: tb/tb_time_syn_ctrl.sv
// -----------------------------------------------------------------------------
// tb_time_syn_ctrl
//   Self-checking bench for time_syn_ctrl: a table of directed exchanges,
//   hand-written stall/reset sequences, and randomized exchanges checked
//   against a transaction-level model of the expected frames and delay.
// -----------------------------------------------------------------------------
module tb_time_syn_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] local_time = '0;
    logic        syn_start = 1'b0;
    logic [63:0] ret_ts = '0;
    logic        ret_valid = 1'b0;
    logic        tvalid;
    logic [63:0] tdata;
    logic        tlast;
    logic [7:0]  tkeep;
    logic        tuser;
    logic        tready = 1'b1;
    logic [63:0] link_delay;
    logic        delay_valid;
    logic        busy;
    logic        syn_fail;

    always #5 clk = ~clk;

    time_syn_ctrl #(.P_TIMEOUT_CYC(32'd16)) dut (
        .i_clk                 (clk),
        .i_rst_n               (rst_n),
        .i_local_time          (local_time),
        .i_syn_start           (syn_start),
        .i_recv_return_ts      (ret_ts),
        .i_recv_return_valid   (ret_valid),
        .m_ctrl_tx_axis_tvalid (tvalid),
        .m_ctrl_tx_axis_tdata  (tdata),
        .m_ctrl_tx_axis_tlast  (tlast),
        .m_ctrl_tx_axis_tkeep  (tkeep),
        .m_ctrl_tx_axis_tuser  (tuser),
        .m_ctrl_tx_axis_tready (tready),
        .o_link_delay          (link_delay),
        .o_delay_valid         (delay_valid),
        .o_syn_busy            (busy),
        .o_syn_fail            (syn_fail)
    );

    typedef struct {
        logic [63:0] d;
        logic        l;
    } beat_t;

    typedef struct {
        logic [63:0] t0;
        logic [63:0] tret;
        int          stall;
        bit          bad;
        logic [63:0] exp_delay;
        logic [63:0] exp_std;
    } vec_t;

    beat_t       beats[$];
    logic [63:0] delays[$];
    int          fails;
    int          errors = 0;
    int          checks = 0;
    vec_t        tbl[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Records what the coming edge will transfer, then advances one cycle.
    // Inputs change and outputs are read 1 time unit after the rising edge.
    task automatic step();
        beat_t b;
        if (tvalid && tready) begin
            b.d = tdata;
            b.l = tlast;
            beats.push_back(b);
        end
        if (delay_valid) delays.push_back(link_delay);
        if (syn_fail) fails++;
        @(posedge clk);
        #1;
        local_time = local_time + 64'd1;
        syn_start  = 1'b0;
        ret_valid  = 1'b0;
    endtask

    task automatic check_exchange(input string name, input logic [63:0] t0,
                                  input logic [63:0] exp_delay, input logic [63:0] exp_std);
        check({name, ".beats"}, 64'(beats.size()), 64'd4);
        if (beats.size() >= 4) begin
            check({name, ".ts0"},  {beats[0].d[62:0], beats[0].l}, {63'h66, 1'b0});
            check({name, ".ts1"},  beats[1].d, t0);
            check({name, ".ts1l"}, 64'(beats[1].l), 64'd1);
            check({name, ".std0"}, {beats[2].d[62:0], beats[2].l}, {63'h88, 1'b0});
            check({name, ".std1"}, beats[3].d, exp_std);
            check({name, ".std1l"}, 64'(beats[3].l), 64'd1);
        end
        check({name, ".npulse"}, 64'(delays.size()), 64'd1);
        if (delays.size() >= 1) check({name, ".delay"}, delays[0], exp_delay);
        check({name, ".idle"}, 64'(busy), 64'd0);
    endtask

    task automatic run_vec(input string name, input vec_t v);
        int n;
        beats.delete();
        delays.delete();
        local_time = v.t0;
        syn_start  = 1'b1;
        step();
        if (v.stall > 0) begin
            step();
            tready = 1'b0;
            for (int k = 0; k < v.stall; k++) begin
                check({name, ".hold_v"}, 64'(tvalid), 64'd1);
                check({name, ".hold_d"}, tdata, v.t0);
                check({name, ".hold_lk"}, {55'd0, tkeep, tlast}, {55'd0, 8'hFF, 1'b1});
                step();
            end
            check({name, ".stallbeats"}, 64'(beats.size()), 64'd1);
            tready = 1'b1;
        end
        n = 0;
        while (beats.size() < 2 && n < 20) begin
            step();
            n++;
        end
        n = 0;
        while (local_time != v.tret && n < 300) begin
            if (v.bad && local_time == v.tret - 64'd2) begin
                ret_ts    = v.t0 - 64'd1;
                ret_valid = 1'b1;
            end
            step();
            n++;
        end
        ret_ts    = v.t0;
        ret_valid = 1'b1;
        step();
        n = 0;
        while ((beats.size() < 4 || busy) && n < 40) begin
            step();
            n++;
        end
        check_exchange(name, v.t0, v.exp_delay, v.exp_std);
    endtask

    initial begin
        int          n;
        int          lat;
        logic [63:0] t0;
        logic [63:0] r;
        logic [63:0] exp_d;

        tbl[0] = '{t0: 64'd1000, tret: 64'd1100, stall: 0, bad: 1'b0, exp_delay: 64'd50, exp_std: 64'd1151};
        tbl[1] = '{t0: 64'd1000, tret: 64'd1100, stall: 0, bad: 1'b1, exp_delay: 64'd50, exp_std: 64'd1151};
        tbl[2] = '{t0: 64'hFFFF_FFFF_FFFF_FFF0, tret: 64'h10, stall: 0, bad: 1'b0, exp_delay: 64'h10, exp_std: 64'h21};
        tbl[3] = '{t0: 64'd0, tret: 64'd20, stall: 5, bad: 1'b0, exp_delay: 64'd10, exp_std: 64'd31};
        tbl[4] = '{t0: 64'd5000, tret: 64'd5007, stall: 0, bad: 1'b0, exp_delay: 64'd3, exp_std: 64'd5011};

        // Reset state
        #1;
        check("rst.tvalid", 64'(tvalid), 64'd0);
        check("rst.tdata", tdata, 64'd0);
        check("rst.misc", {57'd0, tkeep, tuser, tlast, delay_valid, busy, syn_fail} >> 0,
              64'd0);
        check("rst.delay", link_delay, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();

        foreach (tbl[i]) begin
            run_vec($sformatf("vec%0d", i), tbl[i]);
            repeat (2) step();
        end

        // Asynchronous reset while STD0 is stalled on the link
        beats.delete();
        delays.delete();
        local_time = 64'd3000;
        syn_start  = 1'b1;
        step();
        n = 0;
        while (beats.size() < 2 && n < 20) begin
            step();
            n++;
        end
        ret_ts    = 64'd3000;
        ret_valid = 1'b1;
        tready    = 1'b0;
        step();
        step();
        check("rstmid.std0", {tdata[62:0], tvalid}, {63'h88, 1'b1});
        #2;
        rst_n = 1'b0;
        #1;
        check("rstmid.tvalid", 64'(tvalid), 64'd0);
        check("rstmid.busy", 64'(busy), 64'd0);
        check("rstmid.delay", link_delay, 64'd0);
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        tready = 1'b1;
        step();
        run_vec("afterrst", tbl[4]);
        step();

        // Randomized exchanges against the transaction-level model
        for (int it = 0; it < 20; it++) begin
            beats.delete();
            delays.delete();
            t0         = {$urandom, $urandom};
            local_time = t0;
            syn_start  = 1'b1;
            ret_ts     = t0;
            ret_valid  = 1'b1;
            step();
            n = 0;
            while (beats.size() < 2 && n < 100) begin
                tready    = ($urandom_range(3) != 0);
                syn_start = busy && ($urandom_range(7) == 0);
                step();
                n++;
            end
            tready = 1'b1;
            lat = $urandom_range(30);
            for (int k = 0; k < lat; k++) begin
                if ($urandom_range(3) == 0) begin
                    ret_ts    = t0 ^ (64'd1 << $urandom_range(63));
                    ret_valid = 1'b1;
                end
                syn_start = ($urandom_range(5) == 0);
                step();
            end
            r         = local_time;
            ret_ts    = t0;
            ret_valid = 1'b1;
            step();
            n = 0;
            while ((beats.size() < 4 || busy) && n < 100) begin
                tready    = ($urandom_range(3) != 0);
                syn_start = busy && ($urandom_range(7) == 0);
                step();
                n++;
            end
            tready = 1'b1;
            exp_d  = (r - t0) / 64'd2;
            check_exchange($sformatf("rnd%0d", it), t0, exp_d, r + 64'd1 + exp_d);
            step();
        end

`ifdef TIME_SYN_TIMEOUT_EN
        // No RETURN ever arrives: one initial TS frame plus three retries
        beats.delete();
        delays.delete();
        fails      = 0;
        local_time = 64'd7000;
        syn_start  = 1'b1;
        step();
        n = 0;
        while (fails == 0 && n < 600) begin
            step();
            n++;
        end
        begin
            int ts_frames;
            ts_frames = 0;
            foreach (beats[i]) if (beats[i].d == 64'h66 && !beats[i].l) ts_frames++;
            check("tmo.frames", 64'(ts_frames), 64'd4);
        end
        check("tmo.fail", 64'(fails), 64'd1);
        check("tmo.busy", 64'(busy), 64'd0);
        check("tmo.nodelay", 64'(delays.size()), 64'd0);
        step();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
